// File: rtl/ma_mem_ctl_if.sv
// Request/response and data-RAM signal bundle for the MA-stage memory controller.
// The controller sits on the slave modport; the pipe/RAM side drives the master modport.
interface ma_mem_ctl_if #(
    parameter int DRWIDTH = 11
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [DRWIDTH+1:0]   req_adr;
    logic [31:0]          req_wdata;

    logic                 ld_valid;
    logic [31:0]          ld_data;
    logic                 misalign_err;

    logic [DRWIDTH-1:0]   ram_radr;
    logic [31:0]          ram_rdata;
    logic [DRWIDTH-1:0]   ram_wadr;
    logic [31:0]          ram_wdata;
    logic [3:0]           ram_wen;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_adr, req_wdata, ram_rdata,
        output req_ready, ld_valid, ld_data, misalign_err,
        output ram_radr, ram_wadr, ram_wdata, ram_wen
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_adr, req_wdata, ram_rdata,
        input  req_ready, ld_valid, ld_data, misalign_err,
        input  ram_radr, ram_wadr, ram_wdata, ram_wen
    );
endinterface

// File: rtl/ma_mem_ctl.sv
// MA-stage load/store initiator for the byte-lane data RAM (latency-2 loads, same-cycle stores).
// Build option MA_MISALIGN_SPLIT_EN: split word-crossing accesses into two RAM cycles.
module ma_mem_ctl #(
    parameter int DRWIDTH = 11
) (
    input  logic        clk,
    input  logic        rst,
    ma_mem_ctl_if.slave bus
);
    logic [DRWIDTH-1:0] req_wadr;
    logic [1:0]         req_off;
    logic [2:0]         req_nbytes;
    logic               req_cross;
    logic               ready;
    logic               accept;

    logic [DRWIDTH-1:0] wadr;
    logic [DRWIDTH-1:0] radr;
    logic [31:0]        wdata;
    logic [3:0]         wen;

    logic               push_load;
    logic               push_split;
    logic               push_zero;
    logic [1:0]         push_size;
    logic [1:0]         push_off;
    logic               push_uns;
    logic               cap_lo;
    logic               err_pulse;

    logic               s1_valid_q;
    logic               s1_split_q;
    logic               s1_zero_q;
    logic [1:0]         s1_size_q;
    logic [1:0]         s1_off_q;
    logic               s1_uns_q;
    logic [31:0]        lo_buf_q;
    logic               ld_valid_q;
    logic [31:0]        ld_data_q;
    logic [31:0]        ld_data_d;
    logic               err_q;
    logic [63:0]        rd64;
    logic [31:0]        rd_shift;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    assign req_wadr = bus.req_adr[DRWIDTH+1:2];
    assign req_off  = bus.req_adr[1:0];

    always_comb begin
        case (bus.req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
    end

    assign req_cross = ({1'b0, req_off} + req_nbytes) > 3'd4;
    assign accept    = bus.req_valid && ready;

`ifdef MA_MISALIGN_SPLIT_EN
    typedef enum logic {IDLE, SPLIT} state_e;

    state_e             state_q;
    state_e             state_d;
    logic               hold_we_q;
    logic [1:0]         hold_size_q;
    logic [1:0]         hold_off_q;
    logic               hold_uns_q;
    logic [DRWIDTH-1:0] hold_wadr_q;
    logic [31:0]        hold_wdata_q;

    logic               in_split;
    logic [1:0]         cur_size;
    logic [1:0]         cur_off;
    logic               cur_uns;
    logic [31:0]        cur_wdata;
    logic [7:0]         wen8;
    logic [63:0]        wdata64;

    assign in_split  = (state_q == SPLIT);
    assign ready     = !in_split;
    assign cur_size  = in_split ? hold_size_q  : bus.req_size;
    assign cur_off   = in_split ? hold_off_q   : req_off;
    assign cur_uns   = in_split ? hold_uns_q   : bus.req_unsigned;
    assign cur_wdata = in_split ? hold_wdata_q : bus.req_wdata;

    // Shift across an 8-byte window: low half is word wadr, high half is word wadr+1.
    assign wen8    = {4'b0000, size_mask(cur_size)} << cur_off;
    assign wdata64 = {32'h0, cur_wdata} << {cur_off, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_we_q    <= 1'b0;
            hold_size_q  <= 2'b00;
            hold_off_q   <= 2'b00;
            hold_uns_q   <= 1'b0;
            hold_wadr_q  <= '0;
            hold_wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept && req_cross) begin
                hold_we_q    <= bus.req_we;
                hold_size_q  <= bus.req_size;
                hold_off_q   <= req_off;
                hold_uns_q   <= bus.req_unsigned;
                hold_wadr_q  <= req_wadr;
                hold_wdata_q <= bus.req_wdata;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wen        = 4'b0000;
        wadr       = req_wadr;
        radr       = req_wadr;
        wdata      = wdata64[31:0];
        push_load  = 1'b0;
        push_split = 1'b0;
        cap_lo     = 1'b0;
        push_size  = cur_size;
        push_off   = cur_off;
        push_uns   = cur_uns;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_cross) state_d = SPLIT;
                    if (bus.req_we) wen = wen8[3:0];
                    else            push_load = !req_cross;
                end
            end
            SPLIT: begin
                state_d = IDLE;
                wadr    = hold_wadr_q + DRWIDTH'(1);
                radr    = hold_wadr_q + DRWIDTH'(1);
                wdata   = wdata64[63:32];
                if (hold_we_q) begin
                    wen = wen8[7:4];
                end else begin
                    push_load  = 1'b1;
                    push_split = 1'b1;
                    cap_lo     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign push_zero = 1'b0;
    assign err_pulse = 1'b0;
`else
    logic [3:0] wen4;

    assign ready = 1'b1;
    assign wen4  = size_mask(bus.req_size) << req_off;

    // Crossing accesses are rejected: stores are dropped, loads return zero.
    always_comb begin
        wadr       = req_wadr;
        radr       = req_wadr;
        wdata      = bus.req_wdata << {req_off, 3'b000};
        wen        = (accept && bus.req_we && !req_cross) ? wen4 : 4'b0000;
        push_load  = accept && !bus.req_we;
        push_split = 1'b0;
        push_zero  = req_cross;
        push_size  = bus.req_size;
        push_off   = req_off;
        push_uns   = bus.req_unsigned;
        cap_lo     = 1'b0;
        err_pulse  = accept && req_cross;
    end
`endif

    assign rd64     = s1_split_q ? {bus.ram_rdata, lo_buf_q} : {32'h0, bus.ram_rdata};
    assign rd_shift = 32'(rd64 >> {s1_off_q, 3'b000});

    always_comb begin
        ld_data_d = rd_shift;
        case (s1_size_q)
            2'b00: ld_data_d = s1_uns_q ? {24'h0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01: ld_data_d = s1_uns_q ? {16'h0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data_d = rd_shift;
        endcase
        if (s1_zero_q) ld_data_d = 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_split_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_size_q  <= 2'b00;
            s1_off_q   <= 2'b00;
            s1_uns_q   <= 1'b0;
            lo_buf_q   <= 32'h0;
            ld_valid_q <= 1'b0;
            ld_data_q  <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= push_load;
            if (push_load) begin
                s1_split_q <= push_split;
                s1_zero_q  <= push_zero;
                s1_size_q  <= push_size;
                s1_off_q   <= push_off;
                s1_uns_q   <= push_uns;
            end
            if (cap_lo) lo_buf_q <= bus.ram_rdata;
            ld_valid_q <= s1_valid_q;
            if (s1_valid_q) ld_data_q <= ld_data_d;
            err_q <= err_pulse;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.ld_valid     = ld_valid_q;
    assign bus.ld_data      = ld_data_q;
    assign bus.misalign_err = err_q;
    assign bus.ram_radr     = radr;
    assign bus.ram_wadr     = wadr;
    assign bus.ram_wdata    = wdata;
    assign bus.ram_wen      = rst ? 4'b0000 : wen;
endmodule

// File: tb/tb_ma_mem_ctl.sv
// Directed bench for ma_mem_ctl: table of single accesses plus hand-written multi-cycle sequences.
// Crossing-access expectations follow MA_MISALIGN_SPLIT_EN as seen by the bench build.
module tb_ma_mem_ctl;
    localparam int DRW   = 11;
    localparam int DEPTH = 1 << DRW;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ma_mem_ctl_if #(.DRWIDTH(DRW)) bus ();
    ma_mem_ctl #(.DRWIDTH(DRW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [DEPTH];

    // Read-first byte-lane RAM with one-cycle registered read.
    always @(posedge clk) begin
        bus.ram_rdata <= mem[bus.ram_radr];
        for (int i = 0; i < 4; i++)
            if (bus.ram_wen[i]) mem[bus.ram_wadr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [12:0] adr;
        logic [31:0] wdata;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [12:0] adr, input logic [31:0] wd,
                                input logic [3:0] ew, input logic [31:0] ewd,
                                input logic [31:0] eld);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.adr = adr; v.wdata = wd;
        v.exp_wen = ew; v.exp_wdata = ewd; v.exp_ld = eld;
        return v;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] w);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{w[i]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] size, input logic uns,
                         input logic [12:0] adr, input logic [31:0] wd);
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_adr      = adr;
        bus.req_wdata    = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 13'h0, 32'h0);
    endtask

    task automatic do_load(input string name, input logic [1:0] size, input logic uns,
                           input logic [12:0] adr, input int lat, input logic [31:0] exp);
        next_cyc();
        drive(1'b1, 1'b0, size, uns, adr, 32'h0);
        mid();
        for (int k = 1; k <= lat; k++) begin
            next_cyc();
            idle();
            mid();
            if (k < lat) check({name, "_early"}, {31'h0, bus.ld_valid}, 32'h0);
        end
        check({name, "_valid"}, {31'h0, bus.ld_valid}, 32'h1);
        check({name, "_data"}, bus.ld_data, exp);
        $display("[TB] load %s adr=0x%03h lat=%0d data=0x%08h", name, adr, lat, bus.ld_data);
    endtask

    logic [12:0] b2b_adr [4];
    logic [31:0] b2b_exp [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        bus.ram_rdata = 32'h0;
        idle();
        rst = 1'b1;

        vecs[0]  = mk(1, 2'd2, 0, 13'h008, 32'h11223344, 4'b1111, 32'h11223344, 32'h0);
        vecs[1]  = mk(0, 2'd2, 0, 13'h008, 32'h0, 4'b0000, 32'h0, 32'h11223344);
        vecs[2]  = mk(1, 2'd0, 0, 13'h00E, 32'h00000080, 4'b0100, 32'h00800000, 32'h0);
        vecs[3]  = mk(0, 2'd0, 0, 13'h00E, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80);
        vecs[4]  = mk(0, 2'd0, 1, 13'h00E, 32'h0, 4'b0000, 32'h0, 32'h00000080);
        vecs[5]  = mk(1, 2'd1, 0, 13'h011, 32'h00008001, 4'b0110, 32'h00800100, 32'h0);
        vecs[6]  = mk(0, 2'd1, 0, 13'h011, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001);
        vecs[7]  = mk(0, 2'd1, 1, 13'h011, 32'h0, 4'b0000, 32'h0, 32'h00008001);
        vecs[8]  = mk(0, 2'd0, 1, 13'h009, 32'h0, 4'b0000, 32'h0, 32'h00000033);
        vecs[9]  = mk(0, 2'd1, 0, 13'h00A, 32'h0, 4'b0000, 32'h0, 32'h00001122);
        vecs[10] = mk(1, 2'd0, 0, 13'h00B, 32'hFFFFFF7F, 4'b1000, 32'h7F000000, 32'h0);
        vecs[11] = mk(0, 2'd2, 0, 13'h008, 32'h0, 4'b0000, 32'h0, 32'h7F223344);
        vecs[12] = mk(0, 2'd0, 0, 13'h00B, 32'h0, 4'b0000, 32'h0, 32'h0000007F);
        vecs[13] = mk(0, 2'd3, 0, 13'h008, 32'h0, 4'b0000, 32'h0, 32'h7F223344);
        vecs[14] = mk(1, 2'd3, 0, 13'h01C, 32'hA5A55A5A, 4'b1111, 32'hA5A55A5A, 32'h0);
        vecs[15] = mk(0, 2'd2, 1, 13'h01C, 32'h0, 4'b0000, 32'h0, 32'hA5A55A5A);

        // Reset values
        repeat (3) next_cyc();
        mid();
        check("rst_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check("rst_ld_data", bus.ld_data, 32'h0);
        check("rst_misalign", {31'h0, bus.misalign_err}, 32'h0);
        check("rst_wen", {28'h0, bus.ram_wen}, 32'h0);
        next_cyc();
        rst = 1'b0;
        mid();
        check("rst_ready", {31'h0, bus.req_ready}, 32'h1);

        // Table of single, non-crossing accesses
        for (int i = 0; i < NV; i++) begin
            next_cyc();
            drive(1'b1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].adr, vecs[i].wdata);
            mid();
            check("vec_ready", {31'h0, bus.req_ready}, 32'h1);
            if (vecs[i].we) begin
                check("vec_wen", {28'h0, bus.ram_wen}, {28'h0, vecs[i].exp_wen});
                check("vec_wadr", {21'h0, bus.ram_wadr}, {21'h0, vecs[i].adr[12:2]});
                check("vec_wdata", bus.ram_wdata & lanes(vecs[i].exp_wen), vecs[i].exp_wdata);
            end else begin
                check("vec_ld_wen", {28'h0, bus.ram_wen}, 32'h0);
            end
            next_cyc();
            idle();
            mid();
            check("vec_misalign", {31'h0, bus.misalign_err}, 32'h0);
            check("vec_early", {31'h0, bus.ld_valid}, 32'h0);
            next_cyc();
            mid();
            check("vec_ld_valid", {31'h0, bus.ld_valid}, {31'h0, !vecs[i].we});
            if (!vecs[i].we) check("vec_ld_data", bus.ld_data, vecs[i].exp_ld);
            $display("[TB] vec %0d we=%0d size=%0d uns=%0d adr=0x%03h wen=%b ld_valid=%0d ld_data=0x%08h",
                     i, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].adr, vecs[i].exp_wen,
                     bus.ld_valid, bus.ld_data);
        end

        // Four back-to-back aligned loads
        b2b_adr = '{13'h008, 13'h00C, 13'h010, 13'h01C};
        b2b_exp = '{32'h7F223344, 32'h00800000, 32'h00800100, 32'hA5A55A5A};
        for (int k = 0; k < 6; k++) begin
            next_cyc();
            if (k < 4) drive(1'b1, 1'b0, 2'd2, 1'b0, b2b_adr[k], 32'h0);
            else       idle();
            mid();
            if (k < 4) check("b2b_ready", {31'h0, bus.req_ready}, 32'h1);
            if (k < 2) begin
                check("b2b_early", {31'h0, bus.ld_valid}, 32'h0);
            end else begin
                check("b2b_valid", {31'h0, bus.ld_valid}, 32'h1);
                check("b2b_data", bus.ld_data, b2b_exp[k-2]);
                $display("[TB] b2b load %0d data=0x%08h", k - 2, bus.ld_data);
            end
        end

        // Load then store then load on the same word
        next_cyc(); drive(1'b1, 1'b0, 2'd2, 1'b0, 13'h008, 32'h0); mid();
        next_cyc(); drive(1'b1, 1'b1, 2'd2, 1'b0, 13'h008, 32'h12345678); mid();
        check("ls_wen", {28'h0, bus.ram_wen}, 32'hF);
        next_cyc(); drive(1'b1, 1'b0, 2'd2, 1'b0, 13'h008, 32'h0); mid();
        check("ls_pre_valid", {31'h0, bus.ld_valid}, 32'h1);
        check("ls_pre_data", bus.ld_data, 32'h7F223344);
        next_cyc(); idle(); mid();
        check("ls_store_noval", {31'h0, bus.ld_valid}, 32'h0);
        next_cyc(); mid();
        check("ls_post_valid", {31'h0, bus.ld_valid}, 32'h1);
        check("ls_post_data", bus.ld_data, 32'h12345678);
        $display("[TB] load/store/load same word post=0x%08h", bus.ld_data);

`ifdef MA_MISALIGN_SPLIT_EN
        // SH across a word boundary, with an LHU held during SPLIT
        next_cyc(); drive(1'b1, 1'b1, 2'd1, 1'b0, 13'h013, 32'h0000BEEF); mid();
        check("sh_x_ready0", {31'h0, bus.req_ready}, 32'h1);
        check("sh_x_wen0", {28'h0, bus.ram_wen}, 32'h8);
        check("sh_x_wadr0", {21'h0, bus.ram_wadr}, 32'h4);
        check("sh_x_byte0", {24'h0, bus.ram_wdata[31:24]}, 32'hEF);
        next_cyc(); drive(1'b1, 1'b0, 2'd1, 1'b1, 13'h013, 32'h0); mid();
        check("sh_x_ready1", {31'h0, bus.req_ready}, 32'h0);
        check("sh_x_wen1", {28'h0, bus.ram_wen}, 32'h1);
        check("sh_x_wadr1", {21'h0, bus.ram_wadr}, 32'h5);
        check("sh_x_byte1", {24'h0, bus.ram_wdata[7:0]}, 32'hBE);
        next_cyc(); mid();
        check("lhu_x_accept", {31'h0, bus.req_ready}, 32'h1);
        check("lhu_x_nowen", {28'h0, bus.ram_wen}, 32'h0);
        next_cyc(); idle(); mid();
        check("lhu_x_split", {31'h0, bus.req_ready}, 32'h0);
        check("lhu_x_early1", {31'h0, bus.ld_valid}, 32'h0);
        next_cyc(); mid();
        check("lhu_x_early2", {31'h0, bus.ld_valid}, 32'h0);
        next_cyc(); mid();
        check("lhu_x_valid", {31'h0, bus.ld_valid}, 32'h1);
        check("lhu_x_data", bus.ld_data, 32'h0000BEEF);
        $display("[TB] split SH/LHU 0x013 data=0x%08h", bus.ld_data);

        // SW at the top address wraps its high half into word 0
        next_cyc(); drive(1'b1, 1'b1, 2'd2, 1'b0, 13'h1FFE, 32'hCAFEF00D); mid();
        check("sw_top_wen0", {28'h0, bus.ram_wen}, 32'hC);
        check("sw_top_wadr0", {21'h0, bus.ram_wadr}, 32'h7FF);
        check("sw_top_hi", {16'h0, bus.ram_wdata[31:16]}, 32'hF00D);
        next_cyc(); idle(); mid();
        check("sw_top_wen1", {28'h0, bus.ram_wen}, 32'h3);
        check("sw_top_wadr1", {21'h0, bus.ram_wadr}, 32'h0);
        check("sw_top_lo", {16'h0, bus.ram_wdata[15:0]}, 32'hCAFE);
        $display("[TB] split SW top address");
        do_load("lw_top", 2'd2, 1'b0, 13'h1FFE, 3, 32'hCAFEF00D);
        do_load("lw_w0", 2'd2, 1'b0, 13'h000, 2, 32'h0000CAFE);

        // Reset during SPLIT abandons the second half
        next_cyc(); drive(1'b1, 1'b1, 2'd2, 1'b0, 13'h005, 32'h55667788); mid();
        check("rs_wen0", {28'h0, bus.ram_wen}, 32'hE);
        check("rs_wadr0", {21'h0, bus.ram_wadr}, 32'h1);
        next_cyc(); idle(); rst = 1'b1; mid();
        check("rs_wen_rst", {28'h0, bus.ram_wen}, 32'h0);
        check("rs_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check("rs_ld_data", bus.ld_data, 32'h0);
        next_cyc(); rst = 1'b0; mid();
        check("rs_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rs_wen_after", {28'h0, bus.ram_wen}, 32'h0);
        $display("[TB] reset during split store");
        do_load("rs_w1", 2'd2, 1'b0, 13'h004, 2, 32'h66778800);
        do_load("rs_w2", 2'd2, 1'b0, 13'h008, 2, 32'h12345678);
`else
        // Crossing load is rejected: zero result at normal latency, error pulse at t+1
        next_cyc(); drive(1'b1, 1'b0, 2'd2, 1'b0, 13'h001, 32'h0); mid();
        check("xlw_ready", {31'h0, bus.req_ready}, 32'h1);
        check("xlw_wen", {28'h0, bus.ram_wen}, 32'h0);
        next_cyc(); idle(); mid();
        check("xlw_err", {31'h0, bus.misalign_err}, 32'h1);
        check("xlw_early", {31'h0, bus.ld_valid}, 32'h0);
        next_cyc(); mid();
        check("xlw_valid", {31'h0, bus.ld_valid}, 32'h1);
        check("xlw_data", bus.ld_data, 32'h0);
        check("xlw_err_off", {31'h0, bus.misalign_err}, 32'h0);
        $display("[TB] crossing LW 0x001 data=0x%08h", bus.ld_data);

        // Crossing stores write nothing
        next_cyc(); drive(1'b1, 1'b1, 2'd2, 1'b0, 13'h002, 32'hFFFFFFFF); mid();
        check("xsw_wen", {28'h0, bus.ram_wen}, 32'h0);
        next_cyc(); idle(); mid();
        check("xsw_err", {31'h0, bus.misalign_err}, 32'h1);
        next_cyc(); mid();
        check("xsw_noval", {31'h0, bus.ld_valid}, 32'h0);
        next_cyc(); drive(1'b1, 1'b1, 2'd1, 1'b0, 13'h013, 32'h0000BEEF); mid();
        check("xsh_wen", {28'h0, bus.ram_wen}, 32'h0);
        next_cyc(); idle(); mid();
        check("xsh_err", {31'h0, bus.misalign_err}, 32'h1);
        $display("[TB] crossing SW 0x002 / SH 0x013 rejected");
        do_load("xsh_w4", 2'd2, 1'b0, 13'h010, 2, 32'h00800100);
        do_load("xsw_w0", 2'd2, 1'b0, 13'h000, 2, 32'h0);
        do_load("pre_rst", 2'd2, 1'b0, 13'h008, 2, 32'h12345678);
`endif

        // Reset with a load in flight: no result appears
        next_cyc(); drive(1'b1, 1'b0, 2'd2, 1'b0, 13'h01C, 32'h0); mid();
        next_cyc(); idle(); rst = 1'b1; mid();
        check("rp_ld_valid", {31'h0, bus.ld_valid}, 32'h0);
        check("rp_ld_data", bus.ld_data, 32'h0);
        check("rp_misalign", {31'h0, bus.misalign_err}, 32'h0);
        check("rp_wen", {28'h0, bus.ram_wen}, 32'h0);
        next_cyc(); rst = 1'b0; mid();
        check("rp_noval", {31'h0, bus.ld_valid}, 32'h0);
        check("rp_ready", {31'h0, bus.req_ready}, 32'h1);
        $display("[TB] reset with load in flight");

        repeat (2) next_cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
